// File: rtl/adc_ctrl_pkg.sv
// Shared constants and state encoding for the ADC conversion sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc_ctrl_pkg;

  // Default parameter values for adc_conv_ctrl.
  localparam int DEF_DATA_W       = 14;
  localparam int DEF_SCLK_HALF    = 4;
  localparam int DEF_CNV_LOW      = 2;
  localparam int DEF_BUSY_TIMEOUT = 255;

  // Smallest SCLK half-period that still gives Dout time to settle
  // between the ADC's update (after SCLK falls) and our sample point.
  localparam int SCLK_HALF_MIN = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNV     = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    SHIFT   = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2-3 clk cycles from pin change to q.
// Backpressure: none.
// Ports: clk, rst_n (async active-low, resets q to 0), d (async in), q (sync out).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/adc_conv_ctrl.sv
// Conversion sequencer for a dual-channel simultaneous-sampling serial ADC.
// Latency: CNVST low 1 cycle after start; done after CNV_LOW + BUSY handshake + 2*SCLK_HALF*DATA_W cycles.
// Backpressure: none; start is accepted only while ready=1, otherwise dropped.
//
// Ports: CLK/RST_N (async active-low); start/ready/done/data_a/data_b/timeout
// on the host side; CNVST_ADC, CS_ADC, SCLK_ADC out and BUSY_ADC,
// DoutA_ADC, DoutB_ADC in on the ADC side.
// Optional BUSY watchdog: define ADC_CONV_CTRL_TIMEOUT_EN. Without it the
// sequencer waits on BUSY indefinitely and timeout is tied to 0.
module adc_conv_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int SCLK_HALF    = DEF_SCLK_HALF,
  parameter int CNV_LOW      = DEF_CNV_LOW,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic              timeout,
  output logic              CNVST_ADC,
  output logic              CS_ADC,
  output logic              SCLK_ADC,
  input  logic              BUSY_ADC,
  input  logic              DoutA_ADC,
  input  logic              DoutB_ADC
);

  // Out-of-range settings are clamped rather than producing a broken SCLK
  // or a zero-length convert pulse.
  localparam int HALF    = (SCLK_HALF < SCLK_HALF_MIN) ? SCLK_HALF_MIN : SCLK_HALF;
  localparam int CNVL    = (CNV_LOW < 1) ? 1 : CNV_LOW;
  localparam int PH_W    = $clog2(2 * HALF);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_MAX = (CNVL > BUSY_TIMEOUT) ? CNVL : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(HALF);
  localparam logic [PH_W-1:0]  PH_SAMPLE = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNV_LAST  = CNT_W'(CNVL - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  sreg_a_q, sreg_a_d;
  logic [DATA_W-1:0]  sreg_b_q, sreg_b_d;
  logic [DATA_W-1:0]  data_a_q, data_a_d;
  logic [DATA_W-1:0]  data_b_q, data_b_d;
  logic               done_q, done_d;
  logic               cnvst_q, cnvst_d;
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               busy_s;

`ifdef ADC_CONV_CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  logic timeout_q, timeout_d;
`endif

  sync_2ff u_busy_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (BUSY_ADC),
    .q     (busy_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    bit_d    = bit_q;
    sreg_a_d = sreg_a_q;
    sreg_b_d = sreg_b_q;
    data_a_d = data_a_q;
    data_b_d = data_b_q;
`ifdef ADC_CONV_CTRL_TIMEOUT_EN
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CNV;
          cnt_d   = '0;
          ph_d    = '0;
          bit_d   = '0;
`ifdef ADC_CONV_CTRL_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end

      CNV: begin
        if (cnt_q == CNV_LAST) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A BUSY that is already high here is taken as-is; no edge needed.
      WAIT_HI: begin
        if (busy_s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
`ifdef ADC_CONV_CTRL_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      WAIT_LO: begin
        if (!busy_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
          ph_d    = '0;
          bit_d   = '0;
        end
`ifdef ADC_CONV_CTRL_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      // Phases 0..HALF-1 are SCLK low, HALF..2*HALF-1 are SCLK high.
      // Sampling in the last low cycle gives Dout the longest settle time.
      SHIFT: begin
        if (ph_q == PH_SAMPLE) begin
          sreg_a_d = {sreg_a_q[DATA_W-2:0], DoutA_ADC};
          sreg_b_d = {sreg_b_q[DATA_W-2:0], DoutB_ADC};
        end
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d  = DONE;
            data_a_d = sreg_a_q;
            data_b_d = sreg_b_q;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin and strobe flops follow the next state so they line up exactly
    // with the state register and carry no decode glitches.
    done_d  = (state_d == DONE);
    cnvst_d = (state_d != CNV);
    cs_d    = (state_d != SHIFT);
    sclk_d  = !((state_d == SHIFT) && (ph_d < PH_HIGH));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      sreg_a_q <= '0;
      sreg_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      done_q   <= 1'b0;
      cnvst_q  <= 1'b1;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      sreg_a_q <= sreg_a_d;
      sreg_b_q <= sreg_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      done_q   <= done_d;
      cnvst_q  <= cnvst_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
    end
  end

`ifdef ADC_CONV_CTRL_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign data_a    = data_a_q;
  assign data_b    = data_b_q;
  assign CNVST_ADC = cnvst_q;
  assign CS_ADC    = cs_q;
  assign SCLK_ADC  = sclk_q;

endmodule

// File: doc/adc_conv_ctrl.md
# adc_conv_ctrl

Conversion sequencer for the dual-channel, simultaneous-sampling ADC on the memboard. It sits between host-side measurement logic and the ADC pins (CNVST_ADC, BUSY_ADC, CS_ADC, SCLK_ADC, DoutA_ADC, DoutB_ADC). On a start request it issues the convert pulse, tracks BUSY, and serially reads both channels in parallel. It returns two DATA_W-bit words with a one-cycle done strobe.

## Interface
- DATA_W, 14: bits read per channel per conversion.
- SCLK_HALF, 4: SCLK half-period in CLK cycles; must be ≥3.
- CNV_LOW, 2: CNVST_ADC low-pulse width in CLK cycles; must be ≥1.
- BUSY_TIMEOUT, 255: CLK cycles allowed in each BUSY wait state, used only when the watchdog is compiled in.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  reset; asynchronous, active-low. This is already decided.
- start  in  1  request one conversion; sampled only in IDLE.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when data_a/data_b update.
- data_a  out  DATA_W  channel A result, MSB-first assembled.
- data_b  out  DATA_W  channel B result.
- timeout  out  1  sticky watchdog flag; cleared by the next accepted start.
- CNVST_ADC  out  1  convert start, active-low.
- CS_ADC  out  1  serial chip select, active-low.
- SCLK_ADC  out  1  serial clock, idles high.
- BUSY_ADC  in  1  ADC busy; asynchronous to CLK.
- DoutA_ADC / DoutB_ADC  in  1 each  serial data; ADC updates them after each SCLK falling edge.

## Operation
- Reset values: ready=1, done=0, data_a=data_b=0, timeout=0, CNVST_ADC=1, CS_ADC=1, SCLK_ADC=1, state=IDLE.
- BUSY_ADC goes through a 2-flop synchronizer before use (busy_s).
- States and transitions:
  - IDLE: if start=1, go to CNV, clear timeout and the counters.
  - CNV: CNVST_ADC=0 for exactly CNV_LOW cycles, then go to WAIT_HI.
  - WAIT_HI: wait for busy_s=1, then go to WAIT_LO.
  - WAIT_LO: wait for busy_s=0, then go to SHIFT.
  - SHIFT: CS_ADC=0. Run DATA_W SCLK periods, each SCLK_HALF cycles low followed by SCLK_HALF cycles high. On the last CLK cycle of each low phase (the cycle SCLK rises), shift DoutA_ADC into sreg_a and DoutB_ADC into sreg_b, MSB first. After bit DATA_W−1 and its high phase, go to DONE.
  - DONE: CS_ADC=1; data_a/data_b ← shift registers; done=1 for one cycle; then go to IDLE.
- start outside IDLE is ignored and not queued. start held high gives back-to-back conversions separated by one IDLE cycle.
- BUSY already high on entry to WAIT_HI is accepted immediately; no edge is required.
- A BUSY pulse shorter than 2 CLK cycles may be missed. The watchdog (if compiled in) recovers from this.
- Reset asserted mid-operation forces all reset values immediately, including CS_ADC/SCLK_ADC high; no partial data is published.

## Timing
- ready falls in the cycle after start is accepted.
- Convert pulse: CNVST_ADC low starts 1 cycle after start is accepted and lasts CNV_LOW cycles.
- BUSY detection lags the pin by 2–3 CLK cycles (synchronizer).
- Serial phase lasts 2·SCLK_HALF·DATA_W cycles. Default: 112 cycles = 1.12 µs.
- Data sample point is (SCLK_HALF−1) cycles after the SCLK falling edge. With SCLK_HALF≥3 this leaves ≥20 ns for Dout to settle.
- done asserts 1 cycle after the last SCLK rising-edge phase completes. ready returns the cycle after done.

## Configuration
- ADC_CONV_CTRL_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT_HI and in WAIT_LO.
  - On reaching BUSY_TIMEOUT in either state: set timeout=1, CNVST_ADC/CS_ADC/SCLK_ADC to 1, go to IDLE without pulsing done; data outputs are unchanged.
- Not defined: no counter; the block waits indefinitely; timeout is tied to 0.

## Structure
- Package adc_ctrl_pkg holds:
  - state encoding constants: IDLE, CNV, WAIT_HI, WAIT_LO, SHIFT, DONE;
  - default parameter values;
  - the minimum SCLK_HALF constant (3).
- One sub-module, sync_2ff: 2-flop synchronizer with async active-low reset, reset value 0. Instantiated for BUSY_ADC.
- The SCLK phase counter, bit counter and shift registers stay inline.

## Test plan
- Reset then idle: RST_N low for 50 ns, BUSY_ADC=0 → all outputs at reset values; CNVST_ADC stays high for 1 µs with start=0.
- Single conversion: 1-cycle start; ADC model raises BUSY 40 ns after CNVST falls and holds it 700 ns; DoutA streams 0x2AAA, DoutB streams 0x1555 → data_a=0x2AAA, data_b=0x1555, exactly 14 SCLK rising edges, one done pulse, CS_ADC low only during SHIFT.
- Start while active: pulse start during WAIT_LO and again during SHIFT → only one CNVST pulse and one done pulse.
- Back-to-back: start held high for 3 conversions → 3 done pulses, each followed by a 1-cycle ready=1 and a fresh CNVST pulse.
- Watchdog (macro defined, BUSY_TIMEOUT=20): BUSY never rises → timeout=1 about 20 cycles after CNVST returns high, no done, ready=1. A following start with a good BUSY clears timeout and completes.
- Reset mid-SHIFT: deassert RST_N after 5 SCLK bits → CS_ADC=1, SCLK_ADC=1, data_a=0 immediately; after release, a new start completes normally.
